// File: rtl/nco_pkg.sv
// Shared constants, load FSM states and arithmetic helpers for the NCO.
// The sweep helper is only referenced when NCO_SWEEP_EN is defined.
package nco_pkg;

    localparam int ACC_W_DEF   = 16;
    localparam int PHASE_W_DEF = 8;

    typedef enum logic {
        S_LOAD  = 1'b0,
        S_APPLY = 1'b1
    } ld_state_e;

    // Unsigned add clamped to max; operands are zero-extended by the caller.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] max
    );
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[63:0];
    endfunction

endpackage

// File: rtl/nco_phase_gen_if.sv
// Byte-wide valid/ready load port carrying the tuning word, LSB byte first.
interface nco_phase_gen_if;

    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/nco_ftw_loader.sv
// Assembles the tuning word from load bytes into a shadow register and
// issues a one-cycle commit, either immediately or at an accumulator wrap.
module nco_ftw_loader
    import nco_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_valid,
    input  logic [7:0]          load_data,
    input  logic                apply_sync,
    input  logic                carry,
    output logic                load_ready,
    output logic                commit,
    output logic [8*NBYTES-1:0] shadow
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    ld_state_e           state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [8*NBYTES-1:0] shadow_q, shadow_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_LOAD;
            idx_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        commit     = 1'b0;
        load_ready = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            shadow_d[8*i +: 8] = load_data;
                        end
                    end
                    if (idx_q == IDX_W'(NBYTES - 1)) begin
                        idx_d   = '0;
                        state_d = S_APPLY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_APPLY: begin
                // Holding here with en low and apply_sync high is intentional.
                if (!apply_sync || carry) begin
                    commit  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign shadow = shadow_q;

endmodule

// File: rtl/nco_phase_gen.sv
// NCO phase accumulator with byte-loaded tuning word and registered phase.
// Optional NCO_SWEEP_EN adds a saturating per-wrap tuning-word sweep.
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               phase_reset,
    nco_phase_gen_if.slave     ld,
    input  logic               apply_sync,
`ifdef NCO_SWEEP_EN
    input  logic [7:0]         sweep_step,
`endif
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_valid,
    output logic               wrap,
    output logic [ACC_W-1:0]   ftw_out
);

    localparam int NBYTES = ACC_W / 8;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ftw_q, ftw_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               wrap_q, wrap_d;
    logic               vld1_q, vld1_d;
    logic               pvld_q, pvld_d;

    logic [ACC_W:0]     sum;
    logic               carry;
    logic               commit;
    logic               ready;
    logic [ACC_W-1:0]   shadow;

    nco_ftw_loader #(
        .NBYTES(NBYTES)
    ) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(ld.load_valid),
        .load_data (ld.load_data),
        .apply_sync(apply_sync),
        .carry     (carry),
        .load_ready(ready),
        .commit    (commit),
        .shadow    (shadow)
    );

    assign ld.load_ready = ready;

`ifdef NCO_SWEEP_EN
    localparam logic [63:0] ACC_MAX =
        (ACC_W >= 64) ? '1 : ((64'd1 << ACC_W) - 64'd1);
    logic [ACC_W-1:0] ftw_swept;
    assign ftw_swept =
        ACC_W'(sat_add(64'(ftw_q), 64'(sweep_step), ACC_MAX));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            ftw_q   <= '0;
            phase_q <= '0;
            wrap_q  <= 1'b0;
            vld1_q  <= 1'b0;
            pvld_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ftw_q   <= ftw_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            vld1_q  <= vld1_d;
            pvld_q  <= pvld_d;
        end
    end

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, ftw_q};
        acc_d  = acc_q;
        wrap_d = 1'b0;
        carry  = 1'b0;
        if (phase_reset) begin
            acc_d = '0;
        end else if (en) begin
            acc_d  = sum[ACC_W-1:0];
            carry  = sum[ACC_W];
            wrap_d = sum[ACC_W];
        end
        // Phase trails the accumulator by one register stage.
        phase_d = acc_q[ACC_W-1 -: PHASE_W];
        vld1_d  = en | phase_reset;
        pvld_d  = vld1_q;
        ftw_d   = ftw_q;
        if (commit) begin
            ftw_d = shadow;
        end
`ifdef NCO_SWEEP_EN
        else if (carry && ready) begin
            ftw_d = ftw_swept;
        end
`endif
    end

    assign phase_out   = phase_q;
    assign phase_valid = pvld_q;
    assign wrap        = wrap_q;
    assign ftw_out     = ftw_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Bench for nco_phase_gen: vector table, directed corner sequences and
// a randomized run against a cycle-level arithmetic reference model.
module tb_nco_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        phase_reset = 1'b0;
    logic        apply_sync = 1'b0;
    logic [7:0]  phase_out;
    logic        phase_valid;
    logic        wrap;
    logic [15:0] ftw_out;
`ifdef NCO_SWEEP_EN
    logic [7:0]  sweep_step = 8'h00;
`endif

    nco_phase_gen_if lif();

    nco_phase_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .phase_reset(phase_reset),
        .ld         (lif),
        .apply_sync (apply_sync),
`ifdef NCO_SWEEP_EN
        .sweep_step (sweep_step),
`endif
        .phase_out  (phase_out),
        .phase_valid(phase_valid),
        .wrap       (wrap),
        .ftw_out    (ftw_out)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        en;
        logic        pr;
        logic        lv;
        logic [7:0]  ld;
        logic [7:0]  ph;
        logic        pv;
        logic        wr;
        logic [15:0] ftw;
        logic        rdy;
    } vec_t;

    vec_t tbl[10];

    // reference model state (values visible after the most recent edge)
    int  m_acc, m_ftw, m_phase, m_shadow;
    bit  m_wrap, m_pv, m_v1, m_pend;
    int  m_bytes[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] pack(logic [7:0] ph, logic pv,
                                         logic wr, logic [15:0] f,
                                         logic rdy);
        return {5'b0, ph, pv, wr, f, rdy};
    endfunction

    function automatic logic [31:0] dut_pack();
        return pack(phase_out, phase_valid, wrap, ftw_out, lif.load_ready);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!lif.load_ready && n < 1000) begin
            step();
            n++;
        end
        if (!lif.load_ready) begin
            total++;
            $display("FAIL ready_timeout: load_ready stuck at 0");
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        wait_ready();
        lif.load_valid = 1'b1;
        lif.load_data  = b;
        step();
        lif.load_valid = 1'b0;
    endtask

    task automatic m_step(bit rst, bit e, bit pr, bit lv, int ld,
                          bit as, int sw);
        int  sum;
        bit  c;
        if (!rst) begin
            m_acc = 0; m_ftw = 0; m_phase = 0; m_shadow = 0;
            m_wrap = 0; m_pv = 0; m_v1 = 0; m_pend = 0;
            m_bytes.delete();
        end else begin
            sum     = m_acc + m_ftw;
            c       = e && !pr && (sum > 'hFFFF);
            m_phase = m_acc / 256;
            m_pv    = m_v1;
            m_v1    = e || pr;
            if (pr) m_acc = 0;
            else if (e) m_acc = sum % 65536;
            m_wrap = c;
            if (m_pend) begin
                if (!as || c) begin
                    m_ftw  = m_shadow;
                    m_pend = 0;
                end
            end else begin
`ifdef NCO_SWEEP_EN
                if (c) m_ftw = (m_ftw + sw > 'hFFFF) ? 'hFFFF : m_ftw + sw;
`endif
                if (lv) begin
                    m_bytes.push_back(ld);
                    if (m_bytes.size() == 2) begin
                        m_shadow = m_bytes[0] + 256 * m_bytes[1];
                        m_bytes.delete();
                        m_pend = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        int          inc_err, hold_err, last_w, gap, nw, n;
        logic [7:0]  prev;
        bit          seen;
        int          sw;

        lif.load_valid = 1'b0;
        lif.load_data  = 8'h00;
        sw = 0;

        rst_n = 1'b0;
        step();
        step();
        check("reset_state", dut_pack(), pack(8'h00, 0, 0, 16'h0000, 1));

        tbl[0] = '{0, 0, 1, 8'h00, 8'h00, 0, 0, 16'h0000, 1};
        tbl[1] = '{0, 0, 1, 8'h80, 8'h00, 0, 0, 16'h0000, 0};
        tbl[2] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h8000, 1};
        tbl[3] = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 16'h8000, 1};
        tbl[4] = '{1, 0, 0, 8'h00, 8'h80, 1, 1, 16'h8000, 1};
        tbl[5] = '{1, 0, 0, 8'h00, 8'h00, 1, 0, 16'h8000, 1};
        tbl[6] = '{1, 0, 0, 8'h00, 8'h80, 1, 1, 16'h8000, 1};
        tbl[7] = '{1, 1, 0, 8'h00, 8'h00, 1, 0, 16'h8000, 1};
        tbl[8] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 16'h8000, 1};
        tbl[9] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 16'h8000, 1};
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            en             = tbl[i].en;
            phase_reset    = tbl[i].pr;
            lif.load_valid = tbl[i].lv;
            lif.load_data  = tbl[i].ld;
            step();
            check($sformatf("vec%0d", i), dut_pack(),
                  pack(tbl[i].ph, tbl[i].pv, tbl[i].wr,
                       tbl[i].ftw, tbl[i].rdy));
        end
        en = 1'b0;
        phase_reset = 1'b0;
        lif.load_valid = 1'b0;

        // FTW = 0: accumulator frozen, phase still marked valid
        do_reset();
        en = 1'b1;
        repeat (4) step();
        check("ftw0_frozen", dut_pack(), pack(8'h00, 1, 0, 16'h0000, 1));
        en = 1'b0;

        // FTW = 0x0100: phase ramps by one, wrap every 256 cycles
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        step();
        check("ftw_0100", 32'(ftw_out), 32'h0000_0100);
        en = 1'b1;
        step();
        step();
        prev = phase_out;
        inc_err = 0; last_w = -1; gap = 0; nw = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (phase_out != prev + 8'd1) inc_err++;
            prev = phase_out;
            if (wrap) begin
                if (last_w >= 0) gap = c - last_w;
                last_w = c;
                nw++;
            end
        end
        check("ramp_inc_errs", 32'(inc_err), 32'd0);
        check("wrap_gap", 32'(gap), 32'd256);
        check("ramp_valid", 32'(phase_valid), 32'd1);

        // apply_sync: new FTW lands on the wrap edge only
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        step();
        en = 1'b1;
        repeat (8'h40) step();
        apply_sync = 1'b1;
        send_byte(8'h34);
        send_byte(8'h12);
        hold_err = 0;
        seen = 0;
        n = 0;
        while (!seen && n < 400) begin
            if (wrap) seen = 1;
            else begin
                if (ftw_out != 16'h0100) hold_err++;
                step();
                n++;
            end
        end
        check("sync_timeout", 32'(seen), 32'd1);
        check("sync_hold", 32'(hold_err), 32'd0);
        check("sync_ftw", 32'(ftw_out), 32'h0000_1234);
        apply_sync = 1'b0;
        step();
        step();
        check("sync_phase1", 32'(phase_out), 32'h12);
        step();
        check("sync_phase2", 32'(phase_out), 32'h24);
        check("sync_ready", 32'(lif.load_ready), 32'd1);
        en = 1'b0;

        // reset mid-load discards the partial byte
        send_byte(8'h55);
        do_reset();
        check("midrst", 32'({ftw_out, lif.load_ready}), 32'({16'h0, 1'b1}));
        send_byte(8'h01);
        send_byte(8'h00);
        step();
        check("midrst_load", 32'(ftw_out), 32'h0000_0001);

`ifdef NCO_SWEEP_EN
        do_reset();
        sweep_step = 8'h20;
        send_byte(8'hF0);
        send_byte(8'hFF);
        step();
        check("sweep_load", 32'(ftw_out), 32'h0000_FFF0);
        en = 1'b1;
        n = 0;
        step();
        while (!wrap && n < 50) begin
            step();
            n++;
        end
        check("sweep_wrap", 32'(wrap), 32'd1);
        check("sweep_sat", 32'(ftw_out), 32'h0000_FFFF);
        repeat (6) step();
        check("sweep_hold", 32'(ftw_out), 32'h0000_FFFF);
        en = 1'b0;
        sweep_step = 8'h00;
`endif

        // randomized run against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst_n          = (c == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
            en             = ($urandom_range(0, 7) != 0);
            phase_reset    = ($urandom_range(0, 40) == 0);
            lif.load_valid = ($urandom_range(0, 3) == 0);
            lif.load_data  = 8'($urandom_range(0, 255));
            apply_sync     = ($urandom_range(0, 1) == 1);
`ifdef NCO_SWEEP_EN
            sweep_step     = 8'($urandom_range(0, 255));
            sw             = int'(sweep_step);
`endif
            m_step(rst_n, en, phase_reset, lif.load_valid,
                   int'(lif.load_data), apply_sync, sw);
            step();
            check($sformatf("rand%0d", c), dut_pack(),
                  pack(8'(m_phase), m_pv, m_wrap, 16'(m_ftw), !m_pend));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nco_phase_gen.md
Name: nco_phase_gen

Overview:
Numerically controlled oscillator front end. It generates the 8-bit phase stream that drives the sine lookup path. The frequency tuning word (FTW) is loaded over a byte-wide valid/ready port as two bytes. The top level either feeds phase_out directly into the lookup or exposes it on the dedicated outputs.

Parameters:
ACC_W, 16, accumulator and FTW width in bits; must be at least PHASE_W and a multiple of 8
PHASE_W, 8, width of phase_out; the top PHASE_W bits of the accumulator
NBYTES, ACC_W/8, number of load bytes per FTW; derived, not overridden

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
en  in  1  accumulate enable
phase_reset  in  1  synchronous accumulator clear
load_valid  in  1  load byte valid
load_data  in  8  load byte, sent LSB byte first
load_ready  out  1  block can accept a load byte
apply_sync  in  1  1 = apply a new FTW only at an accumulator wrap; 0 = apply immediately
phase_out  out  PHASE_W  current phase
phase_valid  out  1  phase_out was updated this cycle
wrap  out  1  one-cycle pulse on accumulator carry-out
ftw_out  out  ACC_W  active FTW, for readback and debug

Behaviour:
- Single clock domain. Reset is synchronous and active-low: clk/rst_n, sampled on the rising edge of clk.
- Reset values:
  - acc = 0, ftw = 0, shadow = 0
  - phase_out = 0, phase_valid = 0, wrap = 0
  - load_ready = 1, FSM = S_LOAD, byte index = 0
- Accumulator, each cycle, in priority order:
  - phase_reset=1: acc <= 0, wrap <= 0. phase_reset overrides en.
  - else en=1: {carry, acc} <= acc + ftw, computed modulo 2^ACC_W; wrap <= carry.
  - else: acc holds, wrap <= 0.
- Phase output:
  - phase_out is registered and equals the updated acc[ACC_W-1 -: PHASE_W] one cycle after the accumulate edge.
  - phase_valid is en or phase_reset, delayed by that same cycle.
  - Net latency from en asserted to the first phase_valid: 2 clocks.
- Load FSM:
  - S_LOAD (load_ready=1): on load_valid, write load_data into shadow[8*idx +: 8] and increment idx. On the NBYTES-th byte, reset idx to 0 and go to S_APPLY.
  - S_APPLY (load_ready=0; load_valid is ignored):
    - apply_sync=0: ftw <= shadow on the next edge, then return to S_LOAD.
    - apply_sync=1: wait until a cycle whose accumulate produces carry=1. ftw <= shadow on that same edge; the new FTW is first added on the following edge. Then return to S_LOAD.
    - en=0 with apply_sync=1: remain in S_APPLY indefinitely. Deasserting apply_sync releases it next cycle.
- ftw changes only through the FSM, or through sweep when that feature is compiled in.
- FTW=0: acc is frozen even with en=1; phase_valid is still asserted.
- Reset mid-load discards any partial shadow and zeroes ftw.
- ftw_out = ftw, registered.

Optional Feature:
Macro NCO_SWEEP_EN.
- Defined:
  - Adds input port sweep_step (8 bits, unsigned).
  - On every cycle with wrap carry=1 while not in S_APPLY: ftw <= ftw + sweep_step, saturating at 2^ACC_W-1.
  - A commit from S_APPLY in the same cycle takes priority; sweep is skipped for that cycle.
- Undefined: no sweep_step port, and ftw is static between loads.

Decomposition:
- Package nco_pkg holds:
  - ACC_W_DEF and PHASE_W_DEF constants
  - the load FSM state enum typedef (S_LOAD, S_APPLY)
  - a helper function for the saturating add
- One sub-module, nco_ftw_loader: the byte-assembly FSM plus shadow register. It outputs the commit pulse and shadow value.
- The accumulator stays in the top.

Test Plan:
- Load FTW 0x0100 as bytes 0x00, 0x01, then en=1 (apply_sync=0) -> phase_out increments by 1 each cycle; wrap pulses every 256 cycles; ftw_out=0x0100.
- FTW=0x8000, en=1 -> phase_out alternates 0x80, 0x00 and wrap pulses every 2nd cycle. During a load, load_ready drops for exactly 1 cycle after the second byte.
- Running at FTW=0x0100, apply_sync=1, load 0x34, 0x12 at acc=0x4000 -> ftw_out stays 0x0100 until the wrap edge, then becomes 0x1234. The post-wrap increment is 0x1234.
- Assert phase_reset and en together mid-run -> acc=0, wrap=0; the next phase_out is 0x00 with phase_valid=1.
- Send byte 0x55, then drop rst_n for 1 cycle -> ftw_out=0, load_ready=1. A subsequent load of 0x01, 0x00 yields ftw=0x0001 (no stale byte).
- NCO_SWEEP_EN, FTW=0xFFF0, sweep_step=0x20 -> after the first wrap ftw=0xFFFF (saturated); it stays 0xFFFF.
